cipher_save_ctrl: RTL and testbench
===================================

# cipher_save_ctrl

Output-side controller for the ASCON-128 core. It collects 64-bit ciphertext words and the final 128-bit tag from the permutation datapath into a small buffer of enabled 64-bit registers. It arbitrates between ciphertext and tag writes, then drains the buffer to the host through a valid/ready stream. It sits between the datapath's cipher/tag outputs and the top-level output port, and sequences one message at a time.

## Interface
- DEPTH, 4, number of 64-bit buffer entries; power of two, ≥ 2
- CNT_W, 8, width of the block counter
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse that opens a message
- cipher_valid_i  in  1  cipher word available
- cipher_i  in  64  ciphertext word
- cipher_ready_o  out  1  cipher word accepted when high with cipher_valid_i
- tag_valid_i  in  1  tag available
- tag_i  in  128  tag; [127:64] is emitted first
- tag_ready_o  out  1  tag accepted when high with tag_valid_i
- data_o  out  64  head buffer word
- valid_o  out  1  data_o valid
- ready_i  in  1  host consumes data_o
- last_o  out  1  data_o is the final tag word
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse when the message has fully drained
- nb_blocks_o  out  CNT_W  cipher words accepted in the current message

## Operation
- FSM states and transitions:
  - IDLE → DATA on start_i.
  - DATA → TAG_DRAIN on a tag handshake.
  - TAG_DRAIN → IDLE when the last_o word is popped; done_o pulses on that same edge.
- start_i outside IDLE is ignored.
- Entering DATA clears nb_blocks_o and keeps the buffer content. The buffer is empty by construction.
- cipher_ready_o = (state==DATA) && count < DEPTH.
- tag_ready_o = (state==DATA) && count ≤ DEPTH−2 && !cipher_valid_i.
  - Cipher has priority; this is a combinational valid→ready path.
- Cipher handshake: write one entry, last=0, and increment nb_blocks_o. The counter wraps modulo 2^CNT_W.
- Tag handshake: write two entries in the same cycle, tag_i[127:64] (last=0) then tag_i[63:0] (last=1).
- Pop on valid_o && ready_i. Push and pop in the same cycle are both honoured; count changes by pushes minus pops.
- Pointers wrap modulo DEPTH. Overflow and underflow cannot occur: ready never depends on a same-cycle pop.
- data_o and last_o hold their values while valid_o && !ready_i.

## Timing
- All outputs are reset to 0 on reset_i, including data_o, nb_blocks_o, and the FSM (IDLE).
- Reset asserted mid-message discards all entries and the count.
- Latency: a word written at edge N is on data_o with valid_o=1 after edge N (first cycle of N+1) if the buffer was empty.
- Throughput: 1 word/cycle in and out in steady state.
- done_o is high for exactly one cycle, coinciding with the cycle after the final pop. busy_o falls in that same cycle.
- Full buffer with ready_i high: cipher_ready_o stays 0 that cycle and rises the next cycle.

## Configuration
- CIPHER_SAVE_CTRL_CNT_EN defined: nb_blocks_o is a live CNT_W-bit counter as described.
- CIPHER_SAVE_CTRL_CNT_EN undefined: no counter register; nb_blocks_o is tied to 0. All other behaviour is identical.

## Structure
- ascon_pack additions:
  - enum type for the FSM (IDLE, DATA, TAG_DRAIN)
  - constant CIPHER_BUF_DEPTH = 4
  - a 65-bit entry struct {last, word}
- One sub-module, cipher_buf: DEPTH entries with a per-entry write enable, dual write port (two consecutive entries), read pointer, write pointer, and count.
- The FSM and arbitration stay in cipher_save_ctrl.

## Test plan
- Reset, start_i, three cipher words 0x01/0x02/0x03 with ready_i=1, then tag 0xAA..AA_BB..BB → output 0x01, 0x02, 0x03, 0xAA..AA, 0xBB..BB (last_o only on the last word); done_o pulse; nb_blocks_o=3.
- ready_i=0 with 4 cipher words → cipher_ready_o low on the 5th word. Raise ready_i for one cycle → one pop, then cipher_ready_o=1 on the next cycle.
- cipher_valid_i and tag_valid_i high together with count=0 → cipher taken, tag_ready_o=0. Drop cipher_valid_i → tag taken next cycle.
- count=3, tag_valid_i → tag_ready_o=0 until count ≤ 2.
- reset_i asserted mid-message with 2 entries buffered → valid_o=0, busy_o=0, nb_blocks_o=0 immediately. start_i is accepted after release.
- start_i pulsed during TAG_DRAIN → ignored; exactly one done_o pulse.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types for the ASCON output path: save FSM states,
// buffer depth and the {last, word} buffer entry.
package ascon_pack;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAG_DRAIN
  } save_state_t;

  localparam int CIPHER_BUF_DEPTH = 4;

  typedef struct packed {
    logic        last;
    logic [63:0] word;
  } cipher_entry_t;

endpackage

// File: rtl/cipher_buf.sv
// Small circular buffer of enabled 64-bit entries with a dual
// write port (two consecutive slots), one read port and a count.
module cipher_buf
  import ascon_pack::*;
#(
  parameter int DEPTH = CIPHER_BUF_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_one,
  input  logic          push_two,
  input  cipher_entry_t wdata0,
  input  cipher_entry_t wdata1,
  input  logic          pop,
  output cipher_entry_t head,
  output logic [CW-1:0] count
);

  cipher_entry_t    mem [DEPTH];
  logic [AW-1:0]    rp;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    wp1;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] sel_hi;
  logic [CW-1:0]    n_push;

  assign wp1    = wp + AW'(1);
  assign head   = mem[rp];
  assign n_push = push_two ? CW'(2) :
                  push_one ? CW'(1) : '0;

  // Slot wp takes wdata0; slot wp+1 takes wdata1 on a double write.
  always_comb begin
    en     = '0;
    sel_hi = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_hi[i] = push_two && (AW'(i) == wp1);
      en[i]     = ((push_one || push_two) && (AW'(i) == wp))
                  || sel_hi[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (en[i])
          mem[i] <= sel_hi[i] ? wdata1 : wdata0;
      wp    <= wp + AW'(n_push);
      if (pop)
        rp <= rp + AW'(1);
      count <= count + n_push - CW'(pop);
    end
  end

endmodule

// File: rtl/cipher_save_ctrl.sv
// ASCON ciphertext/tag save controller; block counter is built
// only when CIPHER_SAVE_CTRL_CNT_EN is defined.
module cipher_save_ctrl
  import ascon_pack::*;
#(
  parameter int DEPTH = CIPHER_BUF_DEPTH,
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             cipher_valid_i,
  input  logic [63:0]      cipher_i,
  output logic             cipher_ready_o,
  input  logic             tag_valid_i,
  input  logic [127:0]     tag_i,
  output logic             tag_ready_o,
  output logic [63:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] nb_blocks_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] ROOM2 = CW'(DEPTH - 2);

  save_state_t   state;
  cipher_entry_t head;
  cipher_entry_t wdata0;
  cipher_entry_t wdata1;
  logic [CW-1:0] count;
  logic          cipher_hs;
  logic          tag_hs;
  logic          pop;

  // Ready looks only at the registered count, never at a same-cycle pop.
  assign cipher_ready_o = (state == DATA) && (count < FULL);
  assign tag_ready_o    = (state == DATA) && (count <= ROOM2)
                          && !cipher_valid_i;
  assign cipher_hs      = cipher_valid_i && cipher_ready_o;
  assign tag_hs         = tag_valid_i && tag_ready_o;

  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i;
  assign data_o  = head.word;
  assign last_o  = valid_o && head.last;
  assign busy_o  = (state != IDLE);

  assign wdata0 = cipher_hs ? '{last: 1'b0, word: cipher_i}
                            : '{last: 1'b0, word: tag_i[127:64]};
  assign wdata1 = '{last: 1'b1, word: tag_i[63:0]};

  cipher_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clock_i),
    .rst      (reset_i),
    .push_one (cipher_hs),
    .push_two (tag_hs),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE:
          if (start_i)
            state <= DATA;
        DATA:
          if (tag_hs)
            state <= TAG_DRAIN;
        TAG_DRAIN:
          if (pop && head.last) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        default:
          state <= IDLE;
      endcase
    end
  end

`ifdef CIPHER_SAVE_CTRL_CNT_EN
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)
      nb_blocks_o <= '0;
    else if (state == IDLE && start_i)
      nb_blocks_o <= '0;
    else if (cipher_hs)
      nb_blocks_o <= nb_blocks_o + CNT_W'(1);
  end
`else
  assign nb_blocks_o = '0;
`endif

endmodule

// File: tb/tb_cipher_save_ctrl.sv
// Bench for cipher_save_ctrl: vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_cipher_save_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam logic [127:0] TAG = {{8{8'hAA}}, {8{8'hBB}}};

  logic             clock_i = 1'b0;
  logic             reset_i;
  logic             start_i;
  logic             cipher_valid_i;
  logic [63:0]      cipher_i;
  logic             cipher_ready_o;
  logic             tag_valid_i;
  logic [127:0]     tag_i;
  logic             tag_ready_o;
  logic [63:0]      data_o;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] nb_blocks_o;

  cipher_save_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .cipher_valid_i (cipher_valid_i),
    .cipher_i       (cipher_i),
    .cipher_ready_o (cipher_ready_o),
    .tag_valid_i    (tag_valid_i),
    .tag_i          (tag_i),
    .tag_ready_o    (tag_ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .nb_blocks_o    (nb_blocks_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic         st;
    logic         cv;
    logic [63:0]  cw;
    logic         tv;
    logic [127:0] tw;
    logic         rd;
    logic         e_cr;
    logic         e_tr;
    logic         e_v;
    logic [63:0]  e_d;
    logic         e_l;
    logic         e_busy;
    logic         e_done;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  // Reference model: 0 idle, 1 collecting data, 2 draining tag
  int          mode = 0;
  logic [64:0] q[$];
  int          nb = 0;
  bit          done_exp = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int exp_nb();
`ifdef CIPHER_SAVE_CTRL_CNT_EN
    return nb;
`else
    return 0;
`endif
  endfunction

  function automatic vec_t vt(
    input logic st, input logic cv, input logic [63:0] cw,
    input logic tv, input logic [127:0] tw, input logic rd,
    input logic cr, input logic tr, input logic v,
    input logic [63:0] d, input logic l, input logic b,
    input logic dn);
    vec_t r;
    r.st = st; r.cv = cv; r.cw = cw;
    r.tv = tv; r.tw = tw; r.rd = rd;
    r.e_cr = cr; r.e_tr = tr; r.e_v = v;
    r.e_d = d; r.e_l = l; r.e_busy = b; r.e_done = dn;
    return r;
  endfunction

  function automatic vec_t mk(
    input logic st, input logic cv, input logic [63:0] cw,
    input logic tv, input logic [127:0] tw, input logic rd);
    return vt(st, cv, cw, tv, tw, rd, 0, 0, 0, 64'd0, 0, 0, 0);
  endfunction

  task automatic model_reset();
    mode = 0;
    q.delete();
    nb = 0;
    done_exp = 0;
  endtask

  task automatic check_model(input logic cv);
    int n;
    n = q.size();
    chk("cipher_ready", cipher_ready_o, mode == 1 && n < DEPTH);
    chk("tag_ready", tag_ready_o, mode == 1 && n <= DEPTH - 2 && !cv);
    chk("valid", valid_o, n > 0);
    if (n > 0)
      chk("data", data_o, q[0][63:0]);
    chk("last", last_o, n > 0 && q[0][64]);
    chk("busy", busy_o, mode != 0);
    chk("done", done_o, done_exp);
    chk("nb_blocks", nb_blocks_o, exp_nb());
  endtask

  task automatic model_update(input vec_t v);
    int          m0;
    int          n;
    bit          p;
    bit          crdy;
    bit          trdy;
    logic [64:0] h;
    m0   = mode;
    n    = q.size();
    p    = (n > 0) && v.rd;
    crdy = (m0 == 1) && (n < DEPTH);
    trdy = (m0 == 1) && (n <= DEPTH - 2) && !v.cv;
    h    = (n > 0) ? q[0] : 65'd0;
    done_exp = 0;
    if (p)
      void'(q.pop_front());
    if (v.cv && crdy) begin
      q.push_back({1'b0, v.cw});
      nb = (nb + 1) % (1 << CNT_W);
    end
    if (v.tv && trdy) begin
      q.push_back({1'b0, v.tw[127:64]});
      q.push_back({1'b1, v.tw[63:0]});
      mode = 2;
    end
    if (m0 == 0 && v.st) begin
      mode = 1;
      nb = 0;
    end else if (m0 == 2 && p && h[64]) begin
      mode = 0;
      done_exp = 1;
    end
  endtask

  task automatic step(input vec_t v, input bit use_tab);
    start_i        = v.st;
    cipher_valid_i = v.cv;
    cipher_i       = v.cw;
    tag_valid_i    = v.tv;
    tag_i          = v.tw;
    ready_i        = v.rd;
    @(negedge clock_i);
    check_model(v.cv);
    if (done_o)
      done_seen++;
    if (use_tab) begin
      chk("tab_cipher_ready", cipher_ready_o, v.e_cr);
      chk("tab_tag_ready", tag_ready_o, v.e_tr);
      chk("tab_valid", valid_o, v.e_v);
      if (v.e_v)
        chk("tab_data", data_o, v.e_d);
      chk("tab_last", last_o, v.e_l);
      chk("tab_busy", busy_o, v.e_busy);
      chk("tab_done", done_o, v.e_done);
    end
    @(posedge clock_i);
    model_update(v);
    #1;
  endtask

  task automatic finish_msg();
    int k;
    k = 0;
    while (mode != 0 && k < 40) begin
      step(mk(0, 0, 64'd0, mode == 1,
              {$urandom, $urandom, $urandom, $urandom}, 1), 0);
      k++;
    end
    chk("finish_bound", mode, 0);
    step(mk(0, 0, 64'd0, 0, 128'd0, 1), 0);
  endtask

  vec_t tab [9];

  initial begin
    tab[0] = vt(1, 0, 64'd0, 0, 128'd0, 1, 0, 0, 0, 64'd0, 0, 0, 0);
    tab[1] = vt(0, 1, 64'd1, 0, 128'd0, 1, 1, 0, 0, 64'd0, 0, 1, 0);
    tab[2] = vt(0, 1, 64'd2, 0, 128'd0, 1, 1, 0, 1, 64'd1, 0, 1, 0);
    tab[3] = vt(0, 1, 64'd3, 0, 128'd0, 1, 1, 0, 1, 64'd2, 0, 1, 0);
    tab[4] = vt(0, 0, 64'd0, 1, TAG, 1, 1, 1, 1, 64'd3, 0, 1, 0);
    tab[5] = vt(0, 0, 64'd0, 0, 128'd0, 1, 0, 0, 1,
                {8{8'hAA}}, 0, 1, 0);
    tab[6] = vt(0, 0, 64'd0, 0, 128'd0, 1, 0, 0, 1,
                {8{8'hBB}}, 1, 1, 0);
    tab[7] = vt(0, 0, 64'd0, 0, 128'd0, 1, 0, 0, 0, 64'd0, 0, 0, 1);
    tab[8] = vt(0, 0, 64'd0, 0, 128'd0, 1, 0, 0, 0, 64'd0, 0, 0, 0);

    reset_i = 1'b1;
    start_i = 0; cipher_valid_i = 0; cipher_i = '0;
    tag_valid_i = 0; tag_i = '0; ready_i = 0;
    model_reset();
    repeat (2) @(posedge clock_i);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_nb", nb_blocks_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_cready", cipher_ready_o, 0);
    reset_i = 1'b0;

    // Basic message through the vector table
    for (int i = 0; i < 9; i++)
      step(tab[i], 1);
`ifdef CIPHER_SAVE_CTRL_CNT_EN
    chk("nb_final", nb_blocks_o, 3);
`else
    chk("nb_final", nb_blocks_o, 0);
`endif

    // Full buffer with host stalled, then a single pop
    step(mk(1, 0, 64'd0, 0, 128'd0, 0), 0);
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, 64'(i + 16), 0, 128'd0, 0), 0);
    chk("full_cready", cipher_ready_o, 0);
    step(mk(0, 1, 64'h99, 0, 128'd0, 0), 0);
    step(mk(0, 1, 64'h99, 0, 128'd0, 1), 0);
    chk("cready_rise", cipher_ready_o, 1);
    finish_msg();

    // Cipher wins arbitration over tag
    step(mk(1, 0, 64'd0, 0, 128'd0, 1), 0);
    step(mk(0, 1, 64'h55, 1, TAG, 1), 0);
    chk("tag_not_taken", busy_o && !last_o && mode == 1, 1);
    step(mk(0, 0, 64'd0, 1, TAG, 1), 0);
    chk("tag_taken_last", valid_o, 1);
    finish_msg();

    // Tag held off while three entries are buffered
    step(mk(1, 0, 64'd0, 0, 128'd0, 0), 0);
    for (int i = 0; i < 3; i++)
      step(mk(0, 1, 64'(i + 32), 0, 128'd0, 0), 0);
    step(mk(0, 0, 64'd0, 1, TAG, 0), 0);
    step(mk(0, 0, 64'd0, 1, TAG, 0), 0);
    step(mk(0, 0, 64'd0, 1, TAG, 1), 0);
    chk("tag_ready_at_2", tag_ready_o, 1);
    step(mk(0, 0, 64'd0, 1, TAG, 1), 0);
    finish_msg();

    // Reset mid-message discards the buffer
    step(mk(1, 0, 64'd0, 0, 128'd0, 0), 0);
    step(mk(0, 1, 64'h71, 0, 128'd0, 0), 0);
    step(mk(0, 1, 64'h72, 0, 128'd0, 0), 0);
    start_i = 0; cipher_valid_i = 0; tag_valid_i = 0;
    reset_i = 1'b1;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_nb", nb_blocks_o, 0);
    chk("midrst_data", data_o, 0);
    model_reset();
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    step(mk(1, 0, 64'd0, 0, 128'd0, 1), 0);
    chk("restart_busy", busy_o, 1);
    finish_msg();

    // start during tag drain is ignored; one done pulse only
    done_seen = 0;
    step(mk(1, 0, 64'd0, 0, 128'd0, 0), 0);
    step(mk(0, 1, 64'h81, 0, 128'd0, 0), 0);
    step(mk(0, 0, 64'd0, 1, TAG, 0), 0);
    step(mk(1, 0, 64'd0, 0, 128'd0, 0), 0);
    step(mk(1, 0, 64'd0, 0, 128'd0, 1), 0);
    finish_msg();
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 64'd0, 0, 128'd0, 1), 0);
    chk("one_done", done_seen, 1);

    // Random traffic against the model
    for (int i = 0; i < 800; i++)
      step(mk($urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1,
              {$urandom, $urandom},
              $urandom_range(0, 4) == 0,
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 9) < 7), 0);
    finish_msg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
